// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_fifo
// Purpose  : Retirement trace buffer. During a bounded run window it captures
//            every register-file write from the write-back stage (PC, rd,
//            data, cycle stamp) into a FIFO, and presents the entries on a
//            valid/ready drain port. Counts dropped commits on overflow and
//            reports completion once the window has closed and the FIFO is
//            empty.
// Ports    : clk_i, rst_i        clock, async active-high reset
//            start_i             opens the capture window (sampled in IDLE)
//            wb_*_i              write-back stage commit information
//            out_valid_o/ready_i drain handshake, out_*_o head entry fields
//            count_o             FIFO occupancy (0..DEPTH)
//            overflow_o          sticky, a commit was dropped
//            drop_cnt_o          saturating dropped-commit counter
//            done_o              window over and FIFO drained (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_fifo #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     wb_valid_i,
    input  logic                     wb_regwrite_i,
    input  logic [31:0]              wb_pc_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [31:0]              wb_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_pc_o,
    output logic [4:0]               out_rd_o,
    output logic [31:0]              out_data_o,
    output logic [15:0]              out_cycle_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     done_o
);

    localparam int                  c_ADDR_W     = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]   c_DEPTH_CNT  = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]         c_LAST_CYCLE = 16'(MAX_CYCLES - 1);
    localparam logic [15:0]         c_DROP_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_cycle;
    logic [c_ADDR_W-1:0]    r_wptr;
    logic [c_ADDR_W-1:0]    r_rptr;
    logic [c_ADDR_W:0]      r_count;
    logic                   r_overflow;
    logic [15:0]            r_drop_cnt;

    logic [31:0]            r_pc_mem   [DEPTH];
    logic [4:0]             r_rd_mem   [DEPTH];
    logic [31:0]            r_data_mem [DEPTH];
    logic [15:0]            r_cyc_mem  [DEPTH];

    logic                   w_capture;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    // ------------------------------------------------------------------------
    // Handshake / capture decode
    // ------------------------------------------------------------------------
    assign w_capture = (r_state == S_RUN) & wb_valid_i & wb_regwrite_i
                       & (wb_rd_i != 5'd0);
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = ~w_empty & out_ready_i;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push    = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i)                   w_state_nxt = S_RUN;
            S_RUN:   if (r_cycle == c_LAST_CYCLE)   w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty)                   w_state_nxt = S_DONE;
            S_DONE:                                 w_state_nxt = S_DONE;
            default:                                w_state_nxt = S_IDLE;
        endcase
    end

    // Cycle stamp: 0 in the first RUN cycle, frozen once the window closes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle <= '0;
        end else if ((r_state == S_RUN) && (r_cycle != c_LAST_CYCLE)) begin
            r_cycle <= r_cycle + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy (pointers wrap naturally, DEPTH is 2^n)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head fields read zero afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_rd_mem[i]   <= '0;
                r_data_mem[i] <= '0;
                r_cyc_mem[i]  <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wptr]   <= wb_pc_i;
            r_rd_mem[r_wptr]   <= wb_rd_i;
            r_data_mem[r_wptr] <= wb_data_i;
            r_cyc_mem[r_wptr]  <= r_cycle;
        end
    end

    // ------------------------------------------------------------------------
    // Overflow bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != c_DROP_MAX) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registered state
    // ------------------------------------------------------------------------
    assign out_valid_o = ~w_empty;
    assign out_pc_o    = r_pc_mem[r_rptr];
    assign out_rd_o    = r_rd_mem[r_rptr];
    assign out_data_o  = r_data_mem[r_rptr];
    assign out_cycle_o = r_cyc_mem[r_rptr];
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_drop_cnt;
    assign done_o      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_fifo
// Purpose  : Self-checking bench for commit_trace_fifo. A reference model
//            tracks the run window, occupancy, drops and completion, and
//            queues each accepted commit; a separate monitor pops that queue
//            on every drain handshake and compares the head fields.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_fifo;

    localparam int DEPTH = 16;
    localparam int MAX   = 30;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic        wb_regwrite_i = 1'b0;
    logic [31:0] wb_pc_i = '0;
    logic [4:0]  wb_rd_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [4:0]  out_rd_o;
    logic [31:0] out_data_o;
    logic [15:0] out_cycle_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic        done_o;

    commit_trace_fifo #(.DEPTH(DEPTH), .MAX_CYCLES(MAX)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .wb_valid_i   (wb_valid_i),
        .wb_regwrite_i(wb_regwrite_i),
        .wb_pc_i      (wb_pc_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pc_o     (out_pc_o),
        .out_rd_o     (out_rd_o),
        .out_data_o   (out_data_o),
        .out_cycle_o  (out_cycle_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] cyc;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   n_popped = 0;

    // Reference model state: run_cyc = -1 idle, 0..MAX-1 window, MAX after.
    int   model_cnt = 0;
    int   run_cyc = -1;
    int   m_drops = 0;
    bit   m_ovf = 1'b0;
    bit   m_done = 1'b0;
    int   m_cnt0;
    bit   m_pop;
    bit   m_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------------------------------------------------------- model
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            model_cnt = 0;
            run_cyc   = -1;
            m_drops   = 0;
            m_ovf     = 1'b0;
            m_done    = 1'b0;
        end else begin
            check("count", 32'(count_o), model_cnt);
            check("valid", 32'(out_valid_o), 32'(model_cnt != 0));
            check("overflow", 32'(overflow_o), 32'(m_ovf));
            check("drop_cnt", 32'(drop_cnt_o), m_drops);
            check("done", 32'(done_o), 32'(m_done));

            m_cnt0 = model_cnt;
            m_pop  = (model_cnt > 0) && out_ready_i;
            m_req  = (run_cyc >= 0) && (run_cyc < MAX) && wb_valid_i
                     && wb_regwrite_i && (wb_rd_i != 5'd0);
            if (m_req) begin
                if (model_cnt < DEPTH || m_pop) begin
                    exp_q.push_back('{wb_pc_i, wb_rd_i, wb_data_i, 16'(run_cyc)});
                    model_cnt++;
                end else begin
                    if (m_drops < 65535) m_drops++;
                    m_ovf = 1'b1;
                end
            end
            if (m_pop) model_cnt--;
            if (run_cyc >= MAX && m_cnt0 == 0) m_done = 1'b1;
            if (run_cyc < 0) begin
                if (start_i) run_cyc = 0;
            end else if (run_cyc < MAX) begin
                run_cyc++;
            end
        end
    end

    // -------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head_unexpected: actual=entry present required=no entry");
            end else begin
                mon_e = exp_q.pop_front();
                check("head_pc", out_pc_o, mon_e.pc);
                check("head_rd", 32'(out_rd_o), 32'(mon_e.rd));
                check("head_data", out_data_o, mon_e.data);
                check("head_cycle", 32'(out_cycle_o), 32'(mon_e.cyc));
                n_popped++;
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    // Values set now are sampled on the next rising edge; returns at edge+1.
    task automatic step(input bit v, input bit rw, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [31:0] d, input bit rdy);
        wb_valid_i    = v;
        wb_regwrite_i = rw;
        wb_pc_i       = pc;
        wb_rd_i       = rd;
        wb_data_i     = d;
        out_ready_i   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 32'h0, 5'd0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        start_i = 1'b0;
        idle(1'b0);
        idle(1'b0);
        rst_i = 1'b0;
    endtask

    // After return the DUT is in RUN cycle 0.
    task automatic start_run();
        start_i = 1'b1;
        idle(1'b1);
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && !done_o; i++) idle(1'b1);
        check("wait_done", 32'(done_o), 32'd1);
    endtask

    int n0;

    initial begin
        #1;
        do_reset();

        // Reset values
        check("rst_count", 32'(count_o), 0);
        check("rst_valid", 32'(out_valid_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_drop", 32'(drop_cnt_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_pc", out_pc_o, 0);
        check("rst_rd", 32'(out_rd_o), 0);
        check("rst_data", out_data_o, 0);
        check("rst_cycle", 32'(out_cycle_o), 0);

        // Single commit in RUN cycle 3
        start_run();
        idle(1'b1); idle(1'b1); idle(1'b1);
        step(1'b1, 1'b1, 32'h8, 5'd5, 32'd42, 1'b1);
        check("t1_valid", 32'(out_valid_o), 1);
        check("t1_pc", out_pc_o, 32'h8);
        check("t1_rd", 32'(out_rd_o), 5);
        check("t1_data", out_data_o, 42);
        check("t1_cycle", 32'(out_cycle_o), 3);
        idle(1'b1);
        check("t1_count_after_pop", 32'(count_o), 0);
        wait_done();

        // Filtered commits: IDLE, rd=0, regwrite=0
        do_reset();
        step(1'b1, 1'b1, 32'h100, 5'd3, 32'd7, 1'b0);
        step(1'b1, 1'b1, 32'h104, 5'd4, 32'd8, 1'b0);
        check("t2_idle_count", 32'(count_o), 0);
        start_run();
        for (int i = 0; i < 6; i++)
            step(1'b1, i[0], 32'h200 + 32'(i), i[0] ? 5'd0 : 5'd6, 32'(i), 1'b0);
        check("t2_filter_count", 32'(count_o), 0);
        wait_done();

        // Overflow, then full push+pop, then drain
        do_reset();
        n0 = n_popped;
        start_run();
        for (int i = 0; i < 18; i++)
            step(1'b1, 1'b1, 32'h1000 + 32'(4 * i), 5'((i % 31) + 1), 32'(3 * i + 1), 1'b0);
        check("t3_count_full", 32'(count_o), 16);
        check("t3_drops", 32'(drop_cnt_o), 2);
        check("t3_overflow", 32'(overflow_o), 1);
        check("t3_head_pc", out_pc_o, 32'h1000);
        step(1'b1, 1'b1, 32'h2000, 5'd9, 32'hABCD, 1'b1);
        check("t3_pushpop_count", 32'(count_o), 16);
        check("t3_pushpop_drops", 32'(drop_cnt_o), 2);
        check("t3_pushpop_head", out_pc_o, 32'h1004);
        wait_done();
        check("t3_drained", 32'(n_popped - n0), 17);

        // Full window: commit every cycle, one extra after the window
        do_reset();
        n0 = n_popped;
        start_run();
        for (int i = 0; i <= MAX; i++)
            step(1'b1, 1'b1, 32'h4000 + 32'(4 * i), 5'((i % 31) + 1), $urandom, 1'b1);
        wait_done();
        check("t4_captured", 32'(n_popped - n0), MAX);

        // Async reset mid-run with 5 queued, then restart
        do_reset();
        start_run();
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 32'h6000 + 32'(i), 5'd1 + 5'(i), 32'(i), 1'b0);
        check("t5_count5", 32'(count_o), 5);
        #1;
        rst_i = 1'b1;
        #1;
        check("t5_async_count", 32'(count_o), 0);
        check("t5_async_valid", 32'(out_valid_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        start_run();
        step(1'b1, 1'b1, 32'h7000, 5'd2, 32'h55, 1'b0);
        check("t5_restart_cycle", 32'(out_cycle_o), 0);
        wait_done();

        // Randomised runs
        for (int r = 0; r < 4; r++) begin
            do_reset();
            start_run();
            for (int i = 0; i < 45; i++)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom,
                     5'($urandom_range(0, 31)), $urandom,
                     (r % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1));
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Retirement trace buffer sitting between the pipelined CPU's write-back stage and the simulation bench. It captures every architecturally visible register write (PC, destination register, data, cycle stamp) into a FIFO during a bounded run window. It exposes the entries on a valid/ready drain port, so the bench logs commits in order instead of sampling the register file every cycle. It also flags overflow and signals run completion.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- MAX_CYCLES, 30, length of the capture window in clock cycles, 1..65535

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high; clears all state
- start_i  in  1  level; sampled only in IDLE, starts the capture window
- wb_valid_i  in  1  write-back stage holds a valid instruction this cycle
- wb_regwrite_i  in  1  that instruction writes the register file
- wb_pc_i  in  32  PC of the write-back instruction
- wb_rd_i  in  5  destination register index
- wb_data_i  in  32  value written
- out_valid_o  out  1  head entry available
- out_ready_i  in  1  consumer accepts head entry
- out_pc_o  out  32  head entry PC
- out_rd_o  out  5  head entry rd
- out_data_o  out  32  head entry data
- out_cycle_o  out  16  head entry cycle stamp
- count_o  out  log2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky: at least one commit dropped
- drop_cnt_o  out  16  dropped commits, saturating at 16'hFFFF
- done_o  out  1  window ended and FIFO drained; sticky until reset

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: no capture, cycle counter 0. start_i=1 at an edge → RUN.
- RUN: cycle counter increments every cycle, starting at 0 in the first RUN cycle. On the edge where the counter equals MAX_CYCLES-1 → DRAIN. Captures in that final cycle are accepted.
- DRAIN: no capture, counter frozen. count_o==0 at an edge → DONE. Also covers count_o already 0 on entry: DONE follows one cycle later.
- DONE: done_o=1. No capture. Only rst_i leaves DONE; start_i is ignored.
- start_i after IDLE has no effect; deasserting it mid-RUN does not stop the window.
- Capture condition, RUN only: wb_valid_i & wb_regwrite_i & (wb_rd_i != 0). Writes to x0 are never captured.
- Entry pushed = {wb_pc_i, wb_rd_i, wb_data_i, cycle counter value that cycle}.
- Pop: out_valid_o & out_ready_i at an edge removes the head.
- out_valid_o = (count_o != 0). out_* are driven from the head slot. Out fields are don't-care when out_valid_o=0; the bench must not check them.
- Full, push, no pop: entry dropped, drop_cnt_o +1 (saturating), overflow_o set.
- Full, push, pop same edge: both occur, no drop, count unchanged.
- Empty with push: no fall-through. The entry is visible the cycle after the push edge.
- Pointers wrap modulo DEPTH; count_o ranges 0..DEPTH.
- Pops remain legal in DONE, though the FIFO is empty by definition.

## Timing
- Reset values: state IDLE, counter 0, pointers 0, count_o=0, out_valid_o=0, overflow_o=0, drop_cnt_o=0, done_o=0. out_pc_o/out_rd_o/out_data_o/out_cycle_o read 0 (storage cleared).
- rst_i asserted mid-RUN or mid-DRAIN discards all entries immediately (asynchronous), without waiting for a clock edge.
- Push-to-visible latency: 1 cycle.
- Pop takes effect at the edge; the next head appears in the same cycle after the edge.
- Sustained throughput: one push and one pop per cycle.
- Transitions: IDLE→RUN 1 edge after start_i sampled high. RUN lasts exactly MAX_CYCLES cycles. DRAIN→DONE on the first edge where count_o==0.
- Outputs are registered or derived from registered state only. No combinational path from wb_* to out_*. out_valid_o does not depend on out_ready_i.

## Test plan
- Reset then start_i=1, single commit in RUN cycle 3 (pc=0x8, rd=5, data=42) with out_ready_i=1 → one cycle later out_valid_o=1, out_pc_o=8, out_rd_o=5, out_data_o=42, out_cycle_o=3; popped next edge, count_o=0.
- Commits with rd=0, with wb_regwrite_i=0, and any commit while in IDLE → nothing captured, count_o stays 0.
- DEPTH=16, out_ready_i=0, 18 consecutive valid commits → count_o=16, drop_cnt_o=2, overflow_o=1, head = first commit. Then out_ready_i=1 → 16 entries drained in push order.
- Full FIFO with simultaneous push and pop → count_o stays 16, drop_cnt_o unchanged, new entry appears at tail.
- MAX_CYCLES=30, commits every cycle, out_ready_i=1 → exactly 30 entries with stamps 0..29. Commit presented in cycle 30 is not captured. done_o=1 after the FIFO empties.
- Assert rst_i mid-RUN with 5 entries queued → count_o=0, out_valid_o=0 immediately. Restart with start_i → cycle stamps begin at 0 again.
